// File: rtl/sound_irq_latch_if.sv
// Bus between the V33 command port, the Z80 latch/ack strobes and the Z80 interrupt pins.
// The master side drives strobes and data; the slave side is sound_irq_latch.
interface sound_irq_latch_if;
  logic       latch_wr;
  logic [7:0] latch_din;
  logic       latch_rdy;
  logic       z80_latch_rd;
  logic       z80_latch_ack;
  logic [7:0] z80_latch_dout;
  logic       ym_irq_n;
  logic       z80_intack;
  logic       z80_int_n;
  logic [7:0] z80_vector;

  modport master (
    output latch_wr, latch_din, z80_latch_rd, z80_latch_ack, ym_irq_n, z80_intack,
    input  latch_rdy, z80_latch_dout, z80_int_n, z80_vector
  );

  modport slave (
    input  latch_wr, latch_din, z80_latch_rd, z80_latch_ack, ym_irq_n, z80_intack,
    output latch_rdy, z80_latch_dout, z80_int_n, z80_vector
  );
endinterface

// File: rtl/sound_irq_latch.sv
// V33 -> Z80 sound command latch with merged latch/YM2151 interrupt and RST vector.
// Define SOUND_LATCH_FIFO_EN to replace the single overwrite register with a FIFO_DEPTH-entry FIFO.
module sound_irq_latch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_z80,
  sound_irq_latch_if.slave bus
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sound_irq_latch: FIFO_DEPTH must be a power of two in 2..16");
  end

  logic wr_q, rd_q, ack_q;
  logic wr_edge, rd_edge, ack_edge;
  logic push, pop;
  logic queue_empty, empty_nxt;
  logic lirq;
  logic ym_s1, ym_s2, yirq;
  logic intack_unused;

  // Z80-side history only advances on ce_z80 so a strobe is seen once per Z80 cycle.
  assign wr_edge  = bus.latch_wr & ~wr_q;
  assign rd_edge  = ce_z80 & bus.z80_latch_rd & ~rd_q;
  assign ack_edge = ce_z80 & bus.z80_latch_ack & ~ack_q;

  // NOTE: all state is written with <= so every flop samples pre-edge values of its neighbours.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      wr_q <= bus.latch_wr;
      if (ce_z80) begin
        rd_q  <= bus.z80_latch_rd;
        ack_q <= bus.z80_latch_ack;
      end
    end
  end

`ifdef SOUND_LATCH_FIFO_EN
  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             written;

  // A full queue still takes a byte when the same cycle pops one.
  always_comb begin
    pop       = rd_edge && (count != '0);
    push      = wr_edge && ((count != DEPTH_CNT) || pop);
    // NOTE: count_nxt gets its default first, so no branch leaves it unassigned and no latch forms.
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      written <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        written <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // NOTE: storage is not reset; count and written already gate everything the Z80 can see.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= bus.latch_din;
  end

  assign queue_empty        = (count == '0);
  assign empty_nxt          = (count_nxt == '0);
  assign bus.z80_latch_dout = written ? mem[rd_ptr] : 8'hFF;
`else
  logic [7:0] data_q;
  logic       valid_q;

  // Original board behaviour: a second write before the Z80 reads simply replaces the byte.
  assign pop  = rd_edge & valid_q;
  assign push = wr_edge;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      data_q  <= 8'hFF;
      valid_q <= 1'b0;
    end else begin
      if (push) data_q <= bus.latch_din;
      valid_q <= push | (valid_q & ~pop);
    end
  end

  assign queue_empty        = ~valid_q;
  assign empty_nxt          = ~(push | (valid_q & ~pop));
  assign bus.z80_latch_dout = data_q;
`endif

  // A new command beats a simultaneous ack; an ack with entries left keeps the Z80 interrupted.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)                   lirq <= 1'b0;
    else if (wr_edge)               lirq <= 1'b1;
    else if (ack_edge && empty_nxt) lirq <= 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ym_s1 <= 1'b0;
      ym_s2 <= 1'b0;
    end else begin
      ym_s1 <= ~bus.ym_irq_n;
      ym_s2 <= ym_s1;
    end
  end

  assign yirq = ym_s2;

  // The acknowledge cycle only samples the vector; it clears no interrupt source.
  assign intack_unused = bus.z80_intack;

  assign bus.latch_rdy  = ~queue_empty;
  assign bus.z80_int_n  = ~(lirq | yirq);
  assign bus.z80_vector = 8'hFF & ~{3'b000, lirq, 4'b0000} & ~{4'b0000, yirq, 3'b000};

endmodule

// File: tb/tb_sound_irq_latch.sv
// Self-checking bench for sound_irq_latch: directed test-plan steps, then randomized traffic,
// all compared each cycle against a queue-based model of the command path and interrupts.
module tb_sound_irq_latch;

  localparam int DEPTH = 4;
`ifdef SOUND_LATCH_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
  localparam int CAP       = DEPTH;
`else
  localparam bit FIFO_MODE = 1'b0;
  localparam int CAP       = 1;
`endif

  logic clk_sys;
  logic reset_n;
  logic ce_z80;

  sound_irq_latch_if bus ();

  sound_irq_latch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce_z80  (ce_z80),
    .bus     (bus)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending commands as a byte queue, interrupt sources as plain bits.
  logic [7:0] q[$];
  logic [7:0] last_byte;
  bit         ever_wr;
  bit         lirq_m;
  bit         yirq_m;
  bit         ydelay[$];
  bit         prev_wr, prev_rd, prev_ack;

  task automatic model_edge();
    bit wr_e, rd_e, ack_e;
    if (!reset_n) begin
      q.delete();
      ever_wr  = 1'b0;
      lirq_m   = 1'b0;
      yirq_m   = 1'b0;
      prev_wr  = 1'b0;
      prev_rd  = 1'b0;
      prev_ack = 1'b0;
      ydelay.delete();
      ydelay.push_back(1'b0);
      return;
    end
    wr_e  = bus.latch_wr && !prev_wr;
    rd_e  = ce_z80 && bus.z80_latch_rd && !prev_rd;
    ack_e = ce_z80 && bus.z80_latch_ack && !prev_ack;
    prev_wr = bus.latch_wr;
    if (ce_z80) begin
      prev_rd  = bus.z80_latch_rd;
      prev_ack = bus.z80_latch_ack;
    end
    if (rd_e && q.size() > 0) void'(q.pop_front());
    if (wr_e) begin
      if (q.size() < CAP) begin
        q.push_back(bus.latch_din);
        ever_wr   = 1'b1;
        last_byte = bus.latch_din;
      end else if (!FIFO_MODE) begin
        q[q.size()-1] = bus.latch_din;
        ever_wr   = 1'b1;
        last_byte = bus.latch_din;
      end
    end
    if (wr_e)                         lirq_m = 1'b1;
    else if (ack_e && q.size() == 0)  lirq_m = 1'b0;
    // YM request appears two clk_sys edges after ym_irq_n changes.
    yirq_m = ydelay.pop_front();
    ydelay.push_back(!bus.ym_irq_n);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] vec_exp;
    vec_exp = 8'd255 - (lirq_m ? 8'd16 : 8'd0) - (yirq_m ? 8'd8 : 8'd0);
    check1({tag, "/rdy"},   bus.latch_rdy, q.size() != 0);
    check1({tag, "/int_n"}, bus.z80_int_n, !(lirq_m || yirq_m));
    check8({tag, "/vec"},   bus.z80_vector, vec_exp);
    if (q.size() != 0)   check8({tag, "/dout"}, bus.z80_latch_dout, q[0]);
    else if (!ever_wr)   check8({tag, "/dout"}, bus.z80_latch_dout, 8'hFF);
    else if (!FIFO_MODE) check8({tag, "/dout"}, bus.z80_latch_dout, last_byte);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic wr_pulse(input logic [7:0] b);
    bus.latch_wr  = 1'b1;
    bus.latch_din = b;
    cycle("wr");
    bus.latch_wr = 1'b0;
    cycle("wr_lo");
  endtask

  task automatic rd_pulse();
    bus.z80_latch_rd = 1'b1;
    cycle("rd");
    bus.z80_latch_rd = 1'b0;
    cycle("rd_lo");
  endtask

  task automatic ack_pulse();
    bus.z80_latch_ack = 1'b1;
    cycle("ack");
    bus.z80_latch_ack = 1'b0;
    cycle("ack_lo");
  endtask

  initial begin
    reset_n           = 1'b0;
    ce_z80            = 1'b1;
    bus.latch_wr      = 1'b0;
    bus.latch_din     = 8'h00;
    bus.z80_latch_rd  = 1'b0;
    bus.z80_latch_ack = 1'b0;
    bus.ym_irq_n      = 1'b1;
    bus.z80_intack    = 1'b0;

    // Reset values
    cycle("rst");
    cycle("rst");
    check1("rst_rdy", bus.latch_rdy, 1'b0);
    check1("rst_int_n", bus.z80_int_n, 1'b1);
    check8("rst_vec", bus.z80_vector, 8'hFF);
    check8("rst_dout", bus.z80_latch_dout, 8'hFF);
    reset_n = 1'b1;
    cycle("idle");

    // Basic command: write, read, ack
    wr_pulse(8'h3A);
    check1("tp1_rdy", bus.latch_rdy, 1'b1);
    check1("tp1_int_n", bus.z80_int_n, 1'b0);
    check8("tp1_vec", bus.z80_vector, 8'hEF);
    bus.z80_latch_rd = 1'b1;
    check8("tp1_dout_strobe", bus.z80_latch_dout, 8'h3A);
    cycle("tp1_rd");
    bus.z80_latch_rd = 1'b0;
    cycle("tp1_rd_lo");
    ack_pulse();
    check1("tp1_ack_int_n", bus.z80_int_n, 1'b1);
    check1("tp1_ack_rdy", bus.latch_rdy, 1'b0);

    // YM interrupt path and merged vector
    bus.ym_irq_n = 1'b0;
    cycle("ym_fall1");
    check1("ym_not_yet", bus.z80_int_n, 1'b1);
    cycle("ym_fall2");
    check1("ym_int_n", bus.z80_int_n, 1'b0);
    check8("ym_vec", bus.z80_vector, 8'hF7);
    bus.z80_intack = 1'b1;
    wr_pulse(8'h10);
    check8("both_vec", bus.z80_vector, 8'hE7);
    bus.z80_intack = 1'b0;
    bus.ym_irq_n   = 1'b1;
    cycle("ym_rise1");
    cycle("ym_rise2");
    check8("latch_only_vec", bus.z80_vector, 8'hEF);
    rd_pulse();
    ack_pulse();

    // Held write strobe is accepted once
    bus.latch_wr  = 1'b1;
    bus.latch_din = 8'h55;
    repeat (10) cycle("hold");
    bus.latch_wr = 1'b0;
    cycle("hold_lo");
    check8("hold_dout", bus.z80_latch_dout, 8'h55);
    rd_pulse();
    check1("hold_rdy", bus.latch_rdy, 1'b0);
    ack_pulse();

`ifdef SOUND_LATCH_FIFO_EN
    // Queue depth and full drop
    for (int i = 1; i <= 5; i++) wr_pulse(8'(i));
    for (int i = 1; i <= 4; i++) begin
      check8("fifo_head", bus.z80_latch_dout, 8'(i));
      rd_pulse();
      if (i == 1) begin
        ack_pulse();
        check1("fifo_ack_keeps_int", bus.z80_int_n, 1'b0);
      end
    end
    check1("fifo_drained", bus.latch_rdy, 1'b0);
    ack_pulse();
`else
    // Overwrite before read
    wr_pulse(8'h11);
    wr_pulse(8'h22);
    check8("ovw_dout", bus.z80_latch_dout, 8'h22);
    rd_pulse();
    check1("ovw_rdy", bus.latch_rdy, 1'b0);
    check8("ovw_dout_held", bus.z80_latch_dout, 8'h22);
    ack_pulse();
`endif

    // Simultaneous write + read on empty, then on non-empty, then write + ack
    bus.latch_wr = 1'b1; bus.latch_din = 8'hA5; bus.z80_latch_rd = 1'b1;
    cycle("wr_rd_empty");
    bus.latch_wr = 1'b0; bus.z80_latch_rd = 1'b0;
    cycle("wr_rd_empty_lo");
    check1("wr_rd_empty_rdy", bus.latch_rdy, 1'b1);
    bus.latch_wr = 1'b1; bus.latch_din = 8'h5A; bus.z80_latch_rd = 1'b1;
    cycle("wr_rd_full");
    bus.latch_wr = 1'b0; bus.z80_latch_rd = 1'b0;
    cycle("wr_rd_full_lo");
    check8("wr_rd_full_dout", bus.z80_latch_dout, 8'h5A);
    bus.latch_wr = 1'b1; bus.latch_din = 8'hC3; bus.z80_latch_ack = 1'b1;
    cycle("wr_ack");
    bus.latch_wr = 1'b0; bus.z80_latch_ack = 1'b0;
    cycle("wr_ack_lo");
    check1("wr_ack_int_n", bus.z80_int_n, 1'b0);
    repeat (DEPTH + 1) rd_pulse();
    ack_pulse();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n           = ($urandom_range(0, 299) != 0);
      ce_z80            = 1'($urandom_range(0, 1));
      bus.latch_wr      = ($urandom_range(0, 2) == 0);
      bus.latch_din     = 8'($urandom);
      bus.z80_latch_rd  = ($urandom_range(0, 3) == 0);
      bus.z80_latch_ack = ($urandom_range(0, 5) == 0);
      bus.z80_intack    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bus.ym_irq_n = ~bus.ym_irq_n;
      cycle("rnd");
    end

    // Reset with entries pending
    reset_n = 1'b1; ce_z80 = 1'b1;
    bus.latch_wr = 1'b0; bus.z80_latch_rd = 1'b0; bus.z80_latch_ack = 1'b0;
    bus.ym_irq_n = 1'b1; bus.z80_intack = 1'b0;
    cycle("pre_rst");
    cycle("pre_rst");
    wr_pulse(8'h77);
    wr_pulse(8'h88);
    reset_n = 1'b0;
    cycle("mid_rst");
    check1("mid_rst_rdy", bus.latch_rdy, 1'b0);
    check1("mid_rst_int_n", bus.z80_int_n, 1'b1);
    check8("mid_rst_dout", bus.z80_latch_dout, 8'hFF);
    reset_n = 1'b1;
    cycle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
